// File: rtl/shade_pixel_writer_if.sv
// Shaded pixel stream and framebuffer write port of the shade pixel writer.
// The slave modport is the writer's view; the master modport drives it.
interface shade_pixel_writer_if #(
    parameter int RGB_WIDTH  = 8,
    parameter int ADDR_WIDTH = 17
) ();
    logic                   frame_start_in;
    logic [3*RGB_WIDTH-1:0] color_in;
    logic                   color_valid_in;
    logic                   fb_ready_in;
    logic                   fb_we_out;
    logic [ADDR_WIDTH-1:0]  fb_addr_out;
    logic [3*RGB_WIDTH-1:0] fb_data_out;

    modport master (
        output frame_start_in, color_in, color_valid_in, fb_ready_in,
        input  fb_we_out, fb_addr_out, fb_data_out
    );

    modport slave (
        input  frame_start_in, color_in, color_valid_in, fb_ready_in,
        output fb_we_out, fb_addr_out, fb_data_out
    );
endinterface

// File: rtl/shade_pixel_writer.sv
// Buffers the unthrottled shaded pixel stream in a small FIFO and writes each pixel
// to its raster address in the framebuffer through a stallable write register.
module shade_pixel_writer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int RGB_WIDTH  = 8,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                clk,
    input  logic                reset,
    shade_pixel_writer_if.slave px_if,
    output logic                busy_out,
    output logic                frame_done_out,
    output logic                overflow_out
);
    localparam int NPIX  = H_RES * V_RES;
    localparam int PIX_W = 3 * RGB_WIDTH;
    localparam int ENT_W = ADDR_WIDTH + PIX_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(NPIX);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        level_q, level_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]      data_q, data_d;
    logic                  ovf_q, ovf_d;

    // Each entry carries its raster index so dropped pixels leave address gaps.
    logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]      in_entry;
    logic [ENT_W-1:0]      head_entry;

    logic in_run, fifo_empty, fifo_full, can_load, take, bypass, pop, push, drop;

    assign in_run     = (state_q == ST_RUN);
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FIFO_FULL);
    assign can_load   = in_run && (!we_q || px_if.fb_ready_in);
    assign take       = in_run && px_if.color_valid_in && (acc_q < FRAME_PIX);
    // An empty FIFO lets a fresh pixel go straight into the write register.
    assign bypass     = take && can_load && fifo_empty;
    assign pop        = can_load && !fifo_empty;
    assign push       = take && !bypass && (!fifo_full || pop);
    assign drop       = take && fifo_full && !pop;
    assign in_entry   = {acc_q[ADDR_WIDTH-1:0], px_if.color_in};
    assign head_entry = fifo_mem[rd_ptr_q];

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (px_if.frame_start_in) begin
                    state_d = ST_RUN;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (take) acc_d = acc_q + 1'b1;
                if (drop) ovf_d = 1'b1;
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
                if (push && !pop)      level_d = level_q + 1'b1;
                else if (pop && !push) level_d = level_q - 1'b1;
                if ((acc_q == FRAME_PIX) && fifo_empty && (!we_q || px_if.fb_ready_in))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bypass) begin
            we_d   = 1'b1;
            addr_d = acc_q[ADDR_WIDTH-1:0];
            data_d = px_if.color_in;
        end else if (pop) begin
            we_d             = 1'b1;
            {addr_d, data_d} = head_entry;
        end else if (px_if.fb_ready_in) begin
            we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            acc_q    <= acc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; the level counter alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= in_entry;
    end

    assign px_if.fb_we_out   = we_q;
    assign px_if.fb_addr_out = addr_q;
    assign px_if.fb_data_out = data_q;
    assign busy_out          = in_run;
    assign frame_done_out    = (state_q == ST_DONE);
    assign overflow_out      = ovf_q;
endmodule

// File: tb/tb_shade_pixel_writer.sv
// Bench for shade_pixel_writer: a constant vector table, directed corner sequences,
// then random traffic checked against a pending-pixel queue model.
module tb_shade_pixel_writer;
    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int RGB_WIDTH  = 8;
    localparam int ADDR_WIDTH = 3;
    localparam int NPIX       = H_RES * V_RES;
    localparam int PIX_W      = 3 * RGB_WIDTH;

    logic clk;
    logic reset;
    logic busy_out;
    logic frame_done_out;
    logic overflow_out;

    shade_pixel_writer_if #(.RGB_WIDTH(RGB_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) px_if ();

    shade_pixel_writer #(
        .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH),
        .RGB_WIDTH(RGB_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .px_if(px_if),
        .busy_out(busy_out),
        .frame_done_out(frame_done_out),
        .overflow_out(overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        bit start;
        bit valid;
        int pix;
        bit ready;
        bit we;
        int addr;
        bit busy;
        bit done;
    } vec_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [PIX_W-1:0]      data;
    } wr_t;

    // Model: pixels accepted but not yet written (write register plus FIFO).
    wr_t m_q[$];
    bit  m_run;
    bit  m_done;
    bit  m_ovf;
    int  m_acc;

    function automatic vec_t mk(input bit start, input bit valid, input int pix, input bit ready,
                                input bit we, input int addr, input bit busy, input bit done);
        vec_t v;
        v.start = start; v.valid = valid; v.pix = pix; v.ready = ready;
        v.we = we; v.addr = addr; v.busy = busy; v.done = done;
        return v;
    endfunction

    function automatic logic [PIX_W-1:0] pix(input int k);
        logic [7:0] b;
        b = 8'(k + 1);
        return (k == 0) ? 24'h010203 : {b, b, b};
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_acc  = 0;
    endfunction

    // Total buffering is FIFO_DEPTH+1 (FIFO plus write register); a completing write frees a slot.
    function automatic void model_step(input bit start, input bit valid,
                                       input logic [PIX_W-1:0] color, input bit ready);
        int occ;
        bit wr_done;
        occ     = m_q.size();
        wr_done = (occ > 0) && ready;
        if (m_run) begin
            if (m_acc == NPIX && (occ == 0 || (occ == 1 && ready))) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_q.delete();
            end else begin
                if (valid && m_acc < NPIX) begin
                    if (occ - int'(wr_done) < FIFO_DEPTH + 1)
                        m_q.push_back({ADDR_WIDTH'(m_acc), color});
                    else
                        m_ovf = 1'b1;
                    m_acc++;
                end
                if (wr_done) void'(m_q.pop_front());
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            m_run = 1'b1;
            m_acc = 0;
            m_ovf = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input bit start, input bit valid, input logic [PIX_W-1:0] color, input bit ready);
        px_if.frame_start_in = start;
        px_if.color_valid_in = valid;
        px_if.color_in       = color;
        px_if.fb_ready_in    = ready;
        model_step(start, valid, color, ready);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " we"},   px_if.fb_we_out, 0);
        check({tag, " addr"}, px_if.fb_addr_out, 0);
        check({tag, " data"}, px_if.fb_data_out, 0);
        check({tag, " busy"}, busy_out, 0);
        check({tag, " done"}, frame_done_out, 0);
        check({tag, " ovf"},  overflow_out, 0);
    endtask

    task automatic check_wr(input string tag, input int addr);
        check({tag, " we"},   px_if.fb_we_out, 1);
        check({tag, " addr"}, px_if.fb_addr_out, addr);
        check({tag, " data"}, px_if.fb_data_out, pix(addr));
    endtask

    task automatic check_model(input string tag);
        bit exp_we;
        exp_we = (m_q.size() > 0);
        check({tag, " we"}, px_if.fb_we_out, exp_we);
        if (exp_we && px_if.fb_we_out) begin
            check({tag, " addr"}, px_if.fb_addr_out, m_q[0].addr);
            check({tag, " data"}, px_if.fb_data_out, m_q[0].data);
        end
        check({tag, " busy"}, busy_out, m_run);
        check({tag, " done"}, frame_done_out, m_done);
        check({tag, " ovf"},  overflow_out, m_ovf);
    endtask

    initial begin
        vec_t tbl[$];
        int   thresh;

        // Basic frame: back-to-back pixels, writes trail by one cycle.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0));
        for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, k, 1, 1, k, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        // Stall: write to addr 2 held for three cycles while the FIFO absorbs pixels 3..5.
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, k, 1, 1, k, 1, 0));
        for (int k = 3; k < 6; k++) tbl.push_back(mk(0, 1, k, 0, 1, 2, 1, 0));
        tbl.push_back(mk(0, 1, 6, 1, 1, 3, 1, 0));
        tbl.push_back(mk(0, 1, 7, 1, 1, 4, 1, 0));
        for (int a = 5; a < 8; a++) tbl.push_back(mk(0, 0, 0, 1, 1, a, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        px_if.frame_start_in = 1'b0;
        px_if.color_valid_in = 1'b0;
        px_if.color_in       = '0;
        px_if.fb_ready_in    = 1'b0;
        model_clear();
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].start, tbl[i].valid, pix(tbl[i].pix), tbl[i].ready);
            check($sformatf("vec%0d we", i), px_if.fb_we_out, tbl[i].we);
            if (tbl[i].we) begin
                check($sformatf("vec%0d addr", i), px_if.fb_addr_out, tbl[i].addr);
                check($sformatf("vec%0d data", i), px_if.fb_data_out, pix(tbl[i].addr));
            end
            check($sformatf("vec%0d busy", i), busy_out, tbl[i].busy);
            check($sformatf("vec%0d done", i), frame_done_out, tbl[i].done);
            check($sformatf("vec%0d ovf", i), overflow_out, 0);
        end

        // Overflow: six pixels against a stalled port; pixel 5 is dropped, leaving a gap.
        drive(1, 0, '0, 1);
        for (int k = 0; k < 6; k++) drive(0, 1, pix(k), 0);
        check("ovf flag", overflow_out, 1);
        check_wr("ovf hold", 0);
        for (int a = 1; a <= 4; a++) begin
            drive(0, 0, '0, 1);
            check_wr($sformatf("ovf drain%0d", a), a);
        end
        drive(0, 0, '0, 1);
        check("ovf drained we", px_if.fb_we_out, 0);
        drive(0, 1, pix(6), 1);
        check_wr("ovf gap", 6);
        drive(0, 1, pix(7), 1);
        check_wr("ovf last", 7);
        drive(0, 0, '0, 1);
        check("ovf done", frame_done_out, 1);
        check("ovf sticky", overflow_out, 1);
        drive(0, 0, '0, 1);
        check("ovf done pulse", frame_done_out, 0);

        // Full FIFO with a simultaneous pop: the push is accepted, no overflow.
        drive(1, 0, '0, 1);
        check("pp ovf cleared", overflow_out, 0);
        for (int k = 0; k < 5; k++) drive(0, 1, pix(k), 0);
        drive(0, 1, pix(5), 1);
        check("pp no ovf", overflow_out, 0);
        check_wr("pp first", 1);
        for (int k = 6; k < 8; k++) begin
            drive(0, 1, pix(k), 1);
            check_wr($sformatf("pp push%0d", k), k - 4);
        end
        for (int a = 4; a < 8; a++) begin
            drive(0, 0, '0, 1);
            check_wr($sformatf("pp drain%0d", a), a);
        end
        drive(0, 0, '0, 1);
        check("pp done", frame_done_out, 1);
        check("pp ovf end", overflow_out, 0);
        drive(0, 0, '0, 1);

        // Idle pixels are discarded, frame_start in RUN is ignored, a ninth pixel is dropped silently.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, pix(k), 1);
            check($sformatf("idle%0d we", k), px_if.fb_we_out, 0);
            check($sformatf("idle%0d busy", k), busy_out, 0);
        end
        drive(1, 0, '0, 1);
        for (int k = 0; k < 8; k++) begin
            drive(k == 3, 1, pix(k), 1);
            check_wr($sformatf("extra%0d", k), k);
        end
        drive(0, 1, pix(8), 1);
        check("extra done", frame_done_out, 1);
        check("extra we", px_if.fb_we_out, 0);
        check("extra ovf", overflow_out, 0);
        drive(0, 0, '0, 1);

        // Async reset while pixel 3 is being written.
        drive(1, 0, '0, 1);
        for (int k = 0; k < 4; k++) drive(0, 1, pix(k), 1);
        check_wr("pre-rst", 3);
        #1 reset = 1'b0;
        model_clear();
        #1 check_zero("async rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst hold%0d done", c), frame_done_out, 0);
            check($sformatf("rst hold%0d we", c), px_if.fb_we_out, 0);
        end
        reset = 1'b1;
        drive(1, 0, '0, 1);
        drive(0, 1, pix(0), 1);
        check_wr("post-rst", 0);
        check("post-rst ovf", overflow_out, 0);

        // Random traffic against the queue model.
        thresh = 80;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) thresh = $urandom_range(20, 95);
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 99) < 60,
                  PIX_W'($urandom()), $urandom_range(0, 99) < thresh);
            check_model($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
